// File: rtl/jt900h_pkg.sv
// jt900h_pkg: state encoding and register step codes shared by the block-transfer sequencer.
package jt900h_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_CMP  = 3'd3,
        ST_UPD  = 3'd4
    } blk_state_t;

    localparam logic [1:0] STEP_BYTE = 2'd0;
    localparam logic [1:0] STEP_WORD = 2'd1;

endpackage

// File: rtl/jt900h_blkxfer.sv
// jt900h_blkxfer: sequencer for LDI/LDD/LDIR/LDDR and CPI/CPD/CPIR/CPDR; issues memory,
// compare and register-step strobes, while the register file does all the arithmetic.
module jt900h_blkxfer
    import jt900h_pkg::*;
#(
    parameter bit IRQ_CHK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       start,
    input  logic       op_cp,
    input  logic       op_dec,
    input  logic       op_rep,
    input  logic       op_word,
    input  logic       bc_unity,
    input  logic       irq_pend,
    input  logic       mem_ack,
    input  logic       cmp_z,
    output logic       busy,
    output logic       done,
    output logic       again,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       addr_sel,
    output logic       cmp_en,
    output logic       dec_bc,
    output logic       inc_xde,
    output logic       dec_xde,
    output logic       inc_xix,
    output logic       dec_xix,
    output logic [1:0] reg_step,
    output logic       flag_we,
    output logic       flag_v,
    output logic       flag_z
);

    blk_state_t state, state_nx;
    logic       cp, dec, rep, stop, yield;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cp       <= 1'b0;
            dec      <= 1'b0;
            rep      <= 1'b0;
            reg_step <= STEP_BYTE;
            flag_z   <= 1'b0;
        end else if (cen) begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                cp       <= op_cp;
                dec      <= op_dec;
                rep      <= op_rep;
                reg_step <= op_word ? STEP_WORD : STEP_BYTE;
            end
            if (state == ST_CMP) flag_z <= cmp_z;
        end
    end

    // bc_unity still reflects the pre-decrement BC while in UPD
    assign stop  = !rep || bc_unity || (cp && flag_z);
    assign yield = IRQ_CHK && irq_pend;
    assign busy  = state != ST_IDLE;

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        again    = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        addr_sel = 1'b0;
        cmp_en   = 1'b0;
        dec_bc   = 1'b0;
        inc_xde  = 1'b0;
        dec_xde  = 1'b0;
        inc_xix  = 1'b0;
        dec_xix  = 1'b0;
        flag_we  = 1'b0;
        flag_v   = 1'b0;
        case (state)
            ST_IDLE: state_nx = start ? ST_RD : ST_IDLE;
            ST_RD: begin
                mem_rd   = 1'b1;
                state_nx = !mem_ack ? ST_RD : cp ? ST_CMP : ST_WR;
            end
            ST_WR: begin
                mem_wr   = 1'b1;
                addr_sel = 1'b1;
                state_nx = mem_ack ? ST_UPD : ST_WR;
            end
            ST_CMP: begin
                cmp_en   = 1'b1;
                state_nx = ST_UPD;
            end
            ST_UPD: begin
                dec_bc   = 1'b1;
                inc_xix  = !dec;
                dec_xix  = dec;
                inc_xde  = !cp && !dec;
                dec_xde  = !cp && dec;
                flag_we  = 1'b1;
                flag_v   = !bc_unity;
                done     = stop || yield;
                again    = !stop && yield;
                state_nx = (stop || yield) ? ST_IDLE : ST_RD;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_jt900h_blkxfer.sv
// tb_jt900h_blkxfer: random data and timing around the block sequencer, with a register-file and
// memory model and an iteration-level reference that predicts memory, pointers, BC and flags.
module tb_jt900h_blkxfer;
    import jt900h_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, cen = 1'b0, start = 1'b0;
    logic op_cp = 1'b0, op_dec = 1'b0, op_rep = 1'b0, op_word = 1'b0;
    logic bc_unity, irq_pend, mem_ack, cmp_z;
    logic busy, done, again, mem_rd, mem_wr, addr_sel, cmp_en, dec_bc;
    logic inc_xde, dec_xde, inc_xix, dec_xix, flag_we, flag_v, flag_z;
    logic [1:0] reg_step;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    jt900h_blkxfer #(.IRQ_CHK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .start(start),
        .op_cp(op_cp), .op_dec(op_dec), .op_rep(op_rep), .op_word(op_word),
        .bc_unity(bc_unity), .irq_pend(irq_pend), .mem_ack(mem_ack), .cmp_z(cmp_z),
        .busy(busy), .done(done), .again(again), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr_sel(addr_sel), .cmp_en(cmp_en), .dec_bc(dec_bc),
        .inc_xde(inc_xde), .dec_xde(dec_xde), .inc_xix(inc_xix), .dec_xix(dec_xix),
        .reg_step(reg_step), .flag_we(flag_we), .flag_v(flag_v), .flag_z(flag_z)
    );

    // register file and memory environment
    logic [15:0] bc, a_reg, datum;
    logic [31:0] xix, xde;
    logic [15:0] mem[256];
    logic [15:0] mem0[256];
    logic        ld = 1'b0;
    logic [15:0] ld_bc;
    logic [31:0] ld_xix, ld_xde;
    logic [7:0]  addr;
    logic        pend_rd, pend_wr;
    int n_dbc, n_ixix, n_dxix, n_ixde, n_dxde, n_rd, n_wr, n_cmp, n_fwe, n_done, n_again, n_drop;
    int wait_cnt, dly = 0, irq_at = 1 << 20, cyc, st_cyc, dn_cyc;
    logic last_v;

    assign addr     = addr_sel ? xde[7:0] : xix[7:0];
    assign irq_pend = n_dbc >= irq_at;
    assign mem_ack  = (mem_rd || mem_wr) && wait_cnt >= dly;
    assign cmp_z    = mem[xix[7:0]] == a_reg;

    always @(posedge clk) begin
        bc_unity <= ld ? (ld_bc == 16'd1) : (bc == 16'd1);
        if (ld) begin
            bc <= ld_bc; xix <= ld_xix; xde <= ld_xde; mem <= mem0;
            n_dbc <= 0; n_ixix <= 0; n_dxix <= 0; n_ixde <= 0; n_dxde <= 0; n_rd <= 0; n_wr <= 0;
            n_cmp <= 0; n_fwe <= 0; n_done <= 0; n_again <= 0; n_drop <= 0; wait_cnt <= 0;
            cyc <= 0; st_cyc <= 0; dn_cyc <= 0; pend_rd <= 1'b0; pend_wr <= 1'b0; last_v <= 1'b0;
        end else if (rst_n) begin
            cyc <= cyc + 1;
            if ((pend_rd && !mem_rd) || (pend_wr && !mem_wr)) n_drop <= n_drop + 1;
            pend_rd <= mem_rd && !(cen && mem_ack);
            pend_wr <= mem_wr && !(cen && mem_ack);
            if (cen) begin
                if (start && !busy) st_cyc <= cyc;
                if (dec_bc) begin bc <= bc - 16'd1; n_dbc <= n_dbc + 1; end
                if (inc_xix) begin xix <= xix + ((reg_step == STEP_WORD) ? 32'd2 : 32'd1); n_ixix <= n_ixix + 1; end
                if (dec_xix) begin xix <= xix - ((reg_step == STEP_WORD) ? 32'd2 : 32'd1); n_dxix <= n_dxix + 1; end
                if (inc_xde) begin xde <= xde + ((reg_step == STEP_WORD) ? 32'd2 : 32'd1); n_ixde <= n_ixde + 1; end
                if (dec_xde) begin xde <= xde - ((reg_step == STEP_WORD) ? 32'd2 : 32'd1); n_dxde <= n_dxde + 1; end
                if (mem_rd || mem_wr) wait_cnt <= mem_ack ? 0 : wait_cnt + 1;
                if (mem_rd && mem_ack) begin datum <= mem[addr]; n_rd <= n_rd + 1; end
                if (mem_wr && mem_ack) begin mem[addr] <= datum; n_wr <= n_wr + 1; end
                if (cmp_en) n_cmp <= n_cmp + 1;
                if (flag_we) begin n_fwe <= n_fwe + 1; last_v <= flag_v; end
                if (done) begin n_done <= n_done + 1; n_again <= n_again + (again ? 1 : 0); dn_cyc <= cyc; end
            end
        end
    end

    // reference results for the current instruction
    logic [15:0] expm[256];
    logic [15:0] e_bc;
    logic [31:0] e_xix, e_xde;
    int  e_n;
    logic e_again, e_v, e_z, cur_cp, cur_dec, cur_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic setup(input bit cp, input bit dec, input bit rep, input bit word, input logic [15:0] b0,
                         input logic [31:0] x0, input logic [31:0] d0, input int mpos, input int irq_a, input int dmax);
        logic [15:0] b, dt;
        logic [31:0] s, d, st;
        logic last;
        st = word ? 32'd2 : 32'd1;
        a_reg = 16'($urandom);
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 16'($urandom);
            if (mem0[i] == a_reg) mem0[i] = ~a_reg;
        end
        s = x0;
        for (int i = 1; i < mpos; i++) s = dec ? s - st : s + st;
        if (mpos > 0) mem0[s[7:0]] = a_reg;
        for (int i = 0; i < 256; i++) expm[i] = mem0[i];
        b = b0; s = x0; d = d0; e_n = 0; e_again = 1'b0; e_v = 1'b0; e_z = 1'b0;
        while (e_n < 70000) begin
            e_n++;
            dt = expm[s[7:0]];
            e_z = dt == a_reg;
            if (!cp) expm[d[7:0]] = dt;
            last = b == 16'd1;
            b = b - 16'd1;
            s = dec ? s - st : s + st;
            if (!cp) d = dec ? d - st : d + st;
            e_v = !last;
            if (!rep || last || (cp && e_z)) break;
            if (e_n - 1 >= irq_a) begin e_again = 1'b1; break; end
        end
        e_bc = b; e_xix = s; e_xde = d;
        cur_cp = cp; cur_dec = dec; cur_word = word;
        ld_bc = b0; ld_xix = x0; ld_xde = d0;
        @(negedge clk); ld = 1'b1; cen = 1'b0;
        @(negedge clk); ld = 1'b0;
        op_cp = cp; op_dec = dec; op_rep = rep; op_word = word;
        irq_at = irq_a; dly = dmax;
    endtask

    task automatic go(input string tag, input bit crand, input bit chk_lat);
        int cycles, bad;
        start = 1'b1; cen = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".step"}, 32'(reg_step), cur_word ? 32'(STEP_WORD) : 32'(STEP_BYTE));
        cycles = 0;
        while (n_done == 0 && cycles < 20000) begin
            cen = crand ? 1'($urandom) : 1'b1;
            @(negedge clk); cycles++;
        end
        chk({tag, ".timeout"}, 32'(cycles < 20000), 32'd1);
        cen = 1'b1;
        @(negedge clk);
        if (chk_lat) chk({tag, ".lat"}, 32'(dn_cyc - st_cyc), 32'd3);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== expm[i]) bad++;
        chk({tag, ".mem"}, 32'(bad), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(n_done), 32'd1);
        chk({tag, ".again"}, 32'(n_again), 32'(e_again));
        chk({tag, ".bc"}, 32'(bc), 32'(e_bc));
        chk({tag, ".xix"}, xix, e_xix);
        chk({tag, ".xde"}, xde, e_xde);
        chk({tag, ".dec_bc"}, 32'(n_dbc), 32'(e_n));
        chk({tag, ".src_strb"}, 32'(cur_dec ? n_dxix : n_ixix), 32'(e_n));
        chk({tag, ".src_wrong"}, 32'(cur_dec ? n_ixix : n_dxix), 32'd0);
        chk({tag, ".dst_strb"}, 32'(cur_dec ? n_dxde : n_ixde), cur_cp ? 32'd0 : 32'(e_n));
        chk({tag, ".dst_wrong"}, 32'(cur_dec ? n_ixde : n_dxde), 32'd0);
        chk({tag, ".reads"}, 32'(n_rd), 32'(e_n));
        chk({tag, ".writes"}, 32'(n_wr), cur_cp ? 32'd0 : 32'(e_n));
        chk({tag, ".cmps"}, 32'(n_cmp), cur_cp ? 32'(e_n) : 32'd0);
        chk({tag, ".flag_we"}, 32'(n_fwe), 32'(e_n));
        chk({tag, ".flag_v"}, 32'(last_v), 32'(e_v));
        if (cur_cp) chk({tag, ".flag_z"}, 32'(flag_z), 32'(e_z));
        chk({tag, ".held"}, 32'(n_drop), 32'd0);
    endtask

    localparam int NO_IRQ = 1 << 20;

    initial begin
        int cycles;
        #1;
        chk("rst.outs", 32'({busy, done, again, mem_rd, mem_wr, addr_sel, cmp_en, dec_bc, inc_xde, dec_xde,
                             inc_xix, dec_xix, reg_step, flag_we, flag_v, flag_z}), 32'd0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;

        setup(1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 32'd100, 32'd200, 0, NO_IRQ, 0);
        go("ldi", 1'b0, 1'b1);
        setup(1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 32'h20, 32'h80, 0, NO_IRQ, 0);
        go("ldir_w", 1'b0, 1'b0);
        setup(1'b1, 1'b0, 1'b1, 1'b0, 16'd5, 32'h30, 32'h90, 3, NO_IRQ, 0);
        go("cpir", 1'b0, 1'b0);
        setup(1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 32'h70, 32'hF0, 0, 1, 0);
        go("lddr_irq", 1'b0, 1'b0);
        setup(1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 32'h10, 32'h60, 0, NO_IRQ, 3);
        go("ldir_wait", 1'b1, 1'b0);

        // asynchronous reset while writing in the second iteration
        setup(1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 32'h40, 32'hC0, 0, NO_IRQ, 0);
        start = 1'b1; cen = 1'b1;
        @(negedge clk); start = 1'b0;
        cycles = 0;
        while (!(n_rd == 2 && mem_wr) && cycles < 50) begin @(negedge clk); cycles++; end
        chk("rst.reach_wr", 32'(cycles < 50), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst.abort", 32'({busy, done, again, mem_rd, mem_wr, addr_sel, cmp_en, dec_bc, inc_xde, dec_xde,
                                 inc_xix, dec_xix, reg_step, flag_we, flag_v, flag_z}), 32'd0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        chk("rst.idle", 32'(busy), 32'd0);
        setup(1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 32'h50, 32'hA0, 0, NO_IRQ, 0);
        go("post_rst", 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            logic cp, rep;
            cp = 1'($urandom);
            rep = 1'($urandom);
            setup(cp, 1'($urandom), rep, 1'($urandom), 16'($urandom_range(1, 6)), 32'($urandom),
                  32'($urandom), cp ? $urandom_range(0, 6) : 0, rep ? $urandom_range(0, 5) : NO_IRQ,
                  $urandom_range(0, 2));
            go($sformatf("rnd%0d", r), 1'($urandom), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
